// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of the issue, source-check, write-back request and register-file write port
// signals shared between the decode/execute side and the write-back scheduler.
interface regfile_wb_scheduler_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                   issue_valid;
    logic [ADDR_W-1:0]      issue_rd;
    logic                   issue_ready;
    logic [ADDR_W-1:0]      rs1;
    logic [ADDR_W-1:0]      rs2;
    logic                   rs1_busy;
    logic                   rs2_busy;
    logic                   alu_valid;
    logic [ADDR_W-1:0]      alu_rd;
    logic [DATA_W-1:0]      alu_data;
    logic                   alu_ready;
    logic                   lsu_valid;
    logic [ADDR_W-1:0]      lsu_rd;
    logic [DATA_W-1:0]      lsu_data;
    logic                   lsu_ready;
    logic                   rf_we;
    logic [ADDR_W-1:0]      rf_a3;
    logic [DATA_W-1:0]      rf_wd3;
    logic [2**ADDR_W-1:0]   busy_mask;
    logic                   wb_err;

    modport master (
        output issue_valid, issue_rd, rs1, rs2,
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  issue_ready, rs1_busy, rs2_busy, alu_ready, lsu_ready,
        input  rf_we, rf_a3, rf_wd3, busy_mask, wb_err
    );

    modport slave (
        input  issue_valid, issue_rd, rs1, rs2,
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output issue_ready, rs1_busy, rs2_busy, alu_ready, lsu_ready,
        output rf_we, rf_a3, rf_wd3, busy_mask, wb_err
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin write-back arbiter for the register file's single write port, with a
// pending-write scoreboard that exposes RAW/WAW hazards to decode.
module regfile_wb_scheduler #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_wb_scheduler_if.slave  bus
);
    localparam int NREG = 2**ADDR_W;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

    grant_e              last_grant_r;
    logic [NREG-1:0]     busy_r;
    logic [NREG-1:0]     busy_next_s;
    logic                rf_we_r;
    logic [ADDR_W-1:0]   rf_a3_r;
    logic [DATA_W-1:0]   rf_wd3_r;
    logic                wb_err_r;

    logic                alu_grant_s;
    logic                lsu_grant_s;
    logic                hs_s;
    logic [ADDR_W-1:0]   win_rd_s;
    logic [DATA_W-1:0]   win_data_s;
    logic                win_nonzero_s;
    logic                issue_ready_s;
    logic                issue_fire_s;
    logic                err_set_s;

    // Round-robin grant: a tie goes to whichever requester did not win last.
    always_comb begin
        alu_grant_s = 1'b0;
        lsu_grant_s = 1'b0;
        if (bus.alu_valid && bus.lsu_valid) begin
            if (last_grant_r == GRANT_LSU) begin
                alu_grant_s = 1'b1;
            end else begin
                lsu_grant_s = 1'b1;
            end
        end else if (bus.alu_valid) begin
            alu_grant_s = 1'b1;
        end else if (bus.lsu_valid) begin
            lsu_grant_s = 1'b1;
        end else begin
            alu_grant_s = 1'b0;
            lsu_grant_s = 1'b0;
        end
    end

    // Select the winning request's destination and data.
    always_comb begin
        win_rd_s   = {ADDR_W{1'b0}};
        win_data_s = {DATA_W{1'b0}};
        if (lsu_grant_s) begin
            win_rd_s   = bus.lsu_rd;
            win_data_s = bus.lsu_data;
        end else begin
            win_rd_s   = bus.alu_rd;
            win_data_s = bus.alu_data;
        end
    end

    assign hs_s          = alu_grant_s | lsu_grant_s;
    assign win_nonzero_s = (win_rd_s != {ADDR_W{1'b0}});
    assign issue_ready_s = (bus.issue_rd == {ADDR_W{1'b0}}) | ~busy_r[bus.issue_rd];
    assign issue_fire_s  = bus.issue_valid & issue_ready_s;
    assign err_set_s     = hs_s & win_nonzero_s & ~busy_r[win_rd_s];

    // Scoreboard next state: the commit clears first so a same-edge issue re-sets the bit.
    always_comb begin
        busy_next_s = busy_r;
        if (rf_we_r) begin
            busy_next_s[rf_a3_r] = 1'b0;
        end else begin
            busy_next_s = busy_r;
        end
        if (issue_fire_s && (bus.issue_rd != {ADDR_W{1'b0}})) begin
            busy_next_s[bus.issue_rd] = 1'b1;
        end else begin
            busy_next_s[0] = 1'b0;
        end
        busy_next_s[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Arbitration history, updated only when someone is granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= GRANT_LSU;
        end else if (hs_s) begin
            last_grant_r <= lsu_grant_s ? GRANT_LSU : GRANT_ALU;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Write stage: drains every cycle; an x0 write-back is consumed without a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_r  <= 1'b0;
            rf_a3_r  <= {ADDR_W{1'b0}};
            rf_wd3_r <= {DATA_W{1'b0}};
        end else begin
            rf_we_r <= hs_s & win_nonzero_s;
            if (hs_s) begin
                rf_a3_r  <= win_rd_s;
                rf_wd3_r <= win_data_s;
            end else begin
                rf_a3_r  <= rf_a3_r;
                rf_wd3_r <= rf_wd3_r;
            end
        end
    end

    // Sticky flag for a write-back to a register with no outstanding write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_err_r <= 1'b0;
        end else if (err_set_s) begin
            wb_err_r <= 1'b1;
        end else begin
            wb_err_r <= wb_err_r;
        end
    end

    assign bus.issue_ready = issue_ready_s;
    assign bus.rs1_busy    = busy_r[bus.rs1];
    assign bus.rs2_busy    = busy_r[bus.rs2];
    assign bus.alu_ready   = alu_grant_s;
    assign bus.lsu_ready   = lsu_grant_s;
    assign bus.rf_we       = rf_we_r;
    assign bus.rf_a3       = rf_a3_r;
    assign bus.rf_wd3      = rf_wd3_r;
    assign bus.busy_mask   = busy_r;
    assign bus.wb_err      = wb_err_r;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed and randomized bench for regfile_wb_scheduler against a pending-set /
// last-winner reference model.
module tb_regfile_wb_scheduler;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_wb_scheduler_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
    regfile_wb_scheduler #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: set of registers awaiting a write, who won last, staged write.
    bit          pend [NR];
    bit          last_lsu;
    bit          exp_we;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd3;
    bit          exp_err;
    bit          alu_acc;
    bit          lsu_acc;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = 32'd0;
        for (int i = 1; i < NR; i++) m[i] = pend[i];
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        last_lsu = 1'b1;
        exp_we   = 1'b0;
        exp_a3   = 5'd0;
        exp_wd3  = 32'd0;
        exp_err  = 1'b0;
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.alu_valid   = 1'b0;
        bus.lsu_valid   = 1'b0;
    endtask

    // Called at posedge+1 with inputs set; checks at negedge, advances model, returns at posedge+1.
    task automatic cycle();
        bit          ea, el, fire;
        logic [4:0]  rd;
        logic [31:0] d;
        bit          npend [NR];
        @(negedge clk);
        if (bus.alu_valid && bus.lsu_valid) begin
            ea = last_lsu;
            el = !last_lsu;
        end else begin
            ea = bus.alu_valid;
            el = bus.lsu_valid;
        end
        fire = bus.issue_valid && (bus.issue_rd == 5'd0 || !pend[bus.issue_rd]);
        check_eq("alu_ready", 64'(bus.alu_ready), 64'(ea));
        check_eq("lsu_ready", 64'(bus.lsu_ready), 64'(el));
        check_eq("issue_ready", 64'(bus.issue_ready), 64'(bus.issue_rd == 5'd0 || !pend[bus.issue_rd]));
        check_eq("rs1_busy", 64'(bus.rs1_busy), 64'(bus.rs1 != 5'd0 && pend[bus.rs1]));
        check_eq("rs2_busy", 64'(bus.rs2_busy), 64'(bus.rs2 != 5'd0 && pend[bus.rs2]));
        check_eq("busy_mask", 64'(bus.busy_mask), 64'(model_mask()));
        check_eq("rf_we", 64'(bus.rf_we), 64'(exp_we));
        check_eq("wb_err", 64'(bus.wb_err), 64'(exp_err));
        if (exp_we) begin
            check_eq("rf_a3", 64'(bus.rf_a3), 64'(exp_a3));
            check_eq("rf_wd3", 64'(bus.rf_wd3), 64'(exp_wd3));
        end
        rd = el ? bus.lsu_rd : bus.alu_rd;
        d  = el ? bus.lsu_data : bus.alu_data;
        npend = pend;
        if (exp_we) npend[exp_a3] = 1'b0;
        if (fire && bus.issue_rd != 5'd0) npend[bus.issue_rd] = 1'b1;
        if ((ea || el) && rd != 5'd0 && !pend[rd]) exp_err = 1'b1;
        exp_we = (ea || el) && rd != 5'd0;
        if (ea || el) begin
            exp_a3   = rd;
            exp_wd3  = d;
            last_lsu = el;
        end
        pend    = npend;
        alu_acc = ea;
        lsu_acc = el;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_eq("rst_rf_we", 64'(bus.rf_we), 64'd0);
        check_eq("rst_busy_mask", 64'(bus.busy_mask), 64'd0);
        check_eq("rst_wb_err", 64'(bus.wb_err), 64'd0);
        check_eq("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
        check_eq("rst_rs1_busy", 64'(bus.rs1_busy), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = rd;
        cycle();
        bus.issue_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        bus.issue_rd = 5'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
        bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
        bus.lsu_rd = 5'd0; bus.lsu_data = 32'd0;
        #2;
        do_reset();

        // Single ALU write-back
        issue(5'd5);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        cycle();
        bus.alu_valid = 1'b0;
        check_eq("t1_we", 64'(bus.rf_we), 64'd1);
        check_eq("t1_a3", 64'(bus.rf_a3), 64'd5);
        check_eq("t1_wd3", 64'(bus.rf_wd3), 64'hDEADBEEF);
        cycle();
        check_eq("t1_busy5", 64'(bus.busy_mask[5]), 64'd0);
        check_eq("t1_err", 64'(bus.wb_err), 64'd0);

        // Contention: grants alternate starting with ALU
        do_reset();
        for (int i = 1; i <= 4; i++) issue(5'(i));
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1111;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_data = 32'h2222;
        for (int k = 0; k < 4; k++) begin
            #3;
            check_eq("cont_grant", 64'(bus.alu_ready), 64'(k % 2 == 0));
            cycle();
            check_eq("cont_a3", 64'(bus.rf_a3), 64'(k + 1));
            if (alu_acc) begin
                if (bus.alu_rd == 5'd1) begin bus.alu_rd = 5'd3; bus.alu_data = 32'h3333; end
                else bus.alu_valid = 1'b0;
            end
            if (lsu_acc) begin
                if (bus.lsu_rd == 5'd2) begin bus.lsu_rd = 5'd4; bus.lsu_data = 32'h4444; end
                else bus.lsu_valid = 1'b0;
            end
        end
        cycle();

        // Hazards on x7, then x0 issue
        do_reset();
        issue(5'd7);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.rs1 = 5'd7;
        repeat (3) cycle();
        check_eq("haz_iready_blocked", 64'(bus.issue_ready), 64'd0);
        check_eq("haz_rs1_busy", 64'(bus.rs1_busy), 64'd1);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
        cycle();
        bus.alu_valid = 1'b0;
        check_eq("haz_iready_commit", 64'(bus.issue_ready), 64'd0);
        cycle();
        check_eq("haz_iready_free", 64'(bus.issue_ready), 64'd1);
        check_eq("haz_rs1_free", 64'(bus.rs1_busy), 64'd0);
        bus.issue_rd = 5'd0;
        cycle();
        bus.issue_valid = 1'b0;
        check_eq("haz_x0_mask", 64'(bus.busy_mask), 64'd0);

        // Same-edge set and clear of x9 (commit of an unrequested write-back)
        do_reset();
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h99;
        cycle();
        bus.lsu_valid = 1'b0;
        issue(5'd9);
        check_eq("same_edge_busy9", 64'(bus.busy_mask[9]), 64'd1);
        check_eq("same_edge_err", 64'(bus.wb_err), 64'd1);

        // Errors and x0 write-back
        do_reset();
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hABCD;
        cycle();
        bus.lsu_valid = 1'b0;
        check_eq("x0_we", 64'(bus.rf_we), 64'd0);
        check_eq("x0_err", 64'(bus.wb_err), 64'd0);
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd12; bus.lsu_data = 32'hC0FFEE;
        cycle();
        bus.lsu_valid = 1'b0;
        check_eq("err12_we", 64'(bus.rf_we), 64'd1);
        check_eq("err12_err", 64'(bus.wb_err), 64'd1);
        repeat (3) cycle();
        check_eq("err_sticky", 64'(bus.wb_err), 64'd1);

        // Reset while a write is staged
        do_reset();
        issue(5'd3);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h33;
        cycle();
        bus.alu_valid = 1'b0;
        check_eq("mid_we_before", 64'(bus.rf_we), 64'd1);
        do_reset();

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 800; n++) begin
            bus.issue_valid = 1'($urandom % 2);
            bus.issue_rd    = 5'($urandom % 8);
            bus.rs1         = 5'($urandom % 8);
            bus.rs2         = 5'($urandom % 8);
            if (!bus.alu_valid && ($urandom % 3 == 0)) begin
                bus.alu_valid = 1'b1; bus.alu_rd = 5'($urandom % 8); bus.alu_data = $urandom;
            end
            if (!bus.lsu_valid && ($urandom % 3 == 0)) begin
                bus.lsu_valid = 1'b1; bus.lsu_rd = 5'($urandom % 8); bus.lsu_data = $urandom;
            end
            cycle();
            if (alu_acc) bus.alu_valid = 1'b0;
            if (lsu_acc) bus.lsu_valid = 1'b0;
            if ($urandom % 200 == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler and scoreboard for the RV32 integer register file. It shares the register file's single write port (we/a3/wd3) between two write-back requesters, the ALU and the load/store unit, using round-robin arbitration. It also tracks destinations with an outstanding write so the decode stage can stall on RAW and WAW hazards. It sits between the execute/memory units and the register file; its `rf_*` outputs drive the register file's write port directly.

## Interface
Parameters:
- `DATA_W`, 32, write-data width
- `ADDR_W`, 5, register index width (2^ADDR_W registers; index 0 is x0)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `issue_valid`  in  1  decode is issuing an instruction that writes `issue_rd`
- `issue_rd`  in  ADDR_W  destination of the issuing instruction
- `issue_ready`  out  1  issue permitted; combinational
- `rs1`, `rs2`  in  ADDR_W  source indices being decoded
- `rs1_busy`, `rs2_busy`  out  1  source has an outstanding write; combinational
- `alu_valid`, `alu_rd`, `alu_data`  in  1/ADDR_W/DATA_W  ALU write-back request
- `alu_ready`  out  1  ALU request accepted this cycle
- `lsu_valid`, `lsu_rd`, `lsu_data`  in  1/ADDR_W/DATA_W  LSU write-back request
- `lsu_ready`  out  1  LSU request accepted this cycle
- `rf_we`, `rf_a3`, `rf_wd3`  out  1/ADDR_W/DATA_W  register-file write port; registered
- `busy_mask`  out  2^ADDR_W  scoreboard state, bit i = register i pending
- `wb_err`  out  1  sticky error: a write-back arrived for a register that was not pending

## Operation
**Scoreboard**
- `busy_mask[0]` is constant 0.
- `issue_ready = (issue_rd == 0) | ~busy_mask[issue_rd]`. A WAW conflict stalls issue.
- An issue fires on `issue_valid & issue_ready`. If `issue_rd != 0`, it sets `busy_mask[issue_rd]` at the next edge.
- `rsN_busy = busy_mask[rsN]`, so x0 always reads 0.
- A busy bit clears at the edge where the staged write commits to the register file, i.e. at the edge ending a cycle with `rf_we = 1` and `rf_a3 = i`.
- If a set and a clear of the same index fall on the same edge, the set wins.

**Arbitration**
- A handshake occurs when `X_valid & X_ready`. Requesters hold `valid`, `rd` and `data` stable until `ready`.
- One valid requester: it is granted.
- Both valid: the requester not granted most recently wins.
- The `last_grant` register updates only on a grant. Its reset value is LSU, so the ALU wins the first tie.
- At most one `ready` is high per cycle. `ready` depends combinationally on both `valid`s and `last_grant`, never on any `ready`.

**Staging**
- The accepted request is registered into `rf_a3`/`rf_wd3`.
- `rf_we` is asserted only if the granted `rd != 0`. An accepted rd=0 request is consumed with `rf_we = 0`.
- The stage drains every cycle, so there is no back-pressure beyond arbitration.

**Error**
- `wb_err` sets at an edge where a handshake with `rd != 0` occurs and `busy_mask[rd] == 0`.
- `wb_err` clears only on reset.

## Timing
- **Reset values:** `busy_mask = 0`, `rf_we = 0`, `rf_a3 = 0`, `rf_wd3 = 0`, `wb_err = 0`, `last_grant = LSU`. Because `busy_mask = 0`, `issue_ready = 1`, `rs1_busy = 0` and `rs2_busy = 0` combinationally.
- **Mid-operation reset:** any staged write is dropped (`rf_we` forced 0) and all pending bits are lost.
- **Grant to write:** handshake in cycle N gives `rf_we`/`rf_a3`/`rf_wd3` valid in cycle N+1. The register file captures the write at the end of N+1, and the busy bit clears on that same edge.
- **Source visibility:** from cycle N+2 onward, `rsN_busy = 0` and the register file's combinational read returns the new data. There is no bypass.
- **Issue to busy:** an issue in cycle M makes `rsN_busy` high from M+1.
- **Throughput:** one write-back per cycle. Under continuous contention, grants alternate ALU, LSU, ALU, LSU, and so on.

## Test plan
- **Reset then single ALU write:** reset, issue rd=5, ALU valid rd=5 data=0xDEADBEEF. Expect `alu_ready` in N; in N+1 `rf_we = 1`, `rf_a3 = 5`, `rf_wd3 = 0xDEADBEEF`; `busy_mask[5] = 0` in N+2; `wb_err = 0`.
- **Contention:** issue x1, x2, x3, x4; hold ALU (rd 1 then 3) and LSU (rd 2 then 4) valid. Expect grant order ALU, LSU, ALU, LSU on four consecutive cycles, and `rf_a3` sequence 1, 2, 3, 4.
- **Hazards:** issue rd=7, then hold `issue_rd = 7`. Expect `issue_ready = 0`, and `rs1_busy = 1` with `rs1 = 7`, until the cycle after x7 commits. Issue rd=0: `issue_ready = 1` always and `busy_mask` unchanged.
- **Same-edge set and clear:** x9 commits (`rf_we = 1`, `rf_a3 = 9`) on the same edge that issue rd=9 fires. Expect `busy_mask[9] = 1` afterwards.
- **Errors and x0:** LSU write-back rd=12 with no pending bit: expect `wb_err = 1`, sticky, and `rf_we = 1` the next cycle. LSU write-back rd=0: accepted with `rf_we = 0` and no error.
- **Reset mid-flight:** assert `reset` in the cycle where `rf_we = 1`. Expect `rf_we = 0`, `busy_mask = 0` and `wb_err = 0` immediately, with no wait for a clock edge.
